// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war score path.
package tow_pkg;

    typedef enum logic [1:0] {PLAY, HOLD, DONE} tally_state_t;

    localparam int unsigned SCORE_W = 3;

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that times the post-win HOLD phase.
module hold_timer #(
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int unsigned TW = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] LoadVal = TW'(HOLD_CYCLES - 1);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= LoadVal;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - TW'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/win_tally.sv
// Per-player round tally: edge-qualified win counting, post-win hold, restart pulse and
// game-over latch, all from registered outputs.
module win_tally
    import tow_pkg::*;
#(
    parameter int unsigned WIDTH       = SCORE_W,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             win,
    input  logic             clear,
    output logic [WIDTH-1:0] counter,
    output logic             round_reset,
    output logic             game_over
);

    localparam logic [WIDTH-1:0] MaxScore = {WIDTH{1'b1}};

    tally_state_t     state_q;
    logic [WIDTH-1:0] counter_q;
    logic             round_reset_q;
    logic             game_over_q;
    logic             win_q;

    logic rise;
    logic last_win;
    logic timer_load;
    logic timer_dec;
    logic timer_zero;

    assign rise     = win & ~win_q;
    assign last_win = ((counter_q + WIDTH'(1)) == MaxScore);

    // The timer only matters in HOLD, so clear never needs to touch it.
    assign timer_load = ~clear & (state_q == PLAY) & rise & ~last_win;
    assign timer_dec  = ~clear & (state_q == HOLD) & ~timer_zero;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .reset(reset),
        .load (timer_load),
        .dec  (timer_dec),
        .zero (timer_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= PLAY;
            counter_q     <= '0;
            round_reset_q <= 1'b0;
            game_over_q   <= 1'b0;
            win_q         <= 1'b0;
        end else begin
            win_q         <= win;
            round_reset_q <= 1'b0;
            if (clear) begin
                state_q       <= PLAY;
                counter_q     <= '0;
                game_over_q   <= 1'b0;
                round_reset_q <= 1'b1;
            end else begin
                case (state_q)
                    PLAY: begin
                        if (rise) begin
                            counter_q <= counter_q + WIDTH'(1);
                            if (last_win) begin
                                state_q     <= DONE;
                                game_over_q <= 1'b1;
                            end else begin
                                state_q <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (timer_zero) begin
                            state_q       <= PLAY;
                            round_reset_q <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_q <= DONE;
                    end
                    default: begin
                        state_q <= PLAY;
                    end
                endcase
            end
        end
    end

    assign counter     = counter_q;
    assign round_reset = round_reset_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_win_tally.sv
// Bench for win_tally: directed scenarios plus random win/clear/reset traffic against a
// cycle-level score model.
module tb_win_tally;

    localparam int HOLD = 8;
    localparam int MAXS = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       win;
    logic       clear;
    logic [2:0] counter;
    logic       round_reset;
    logic       game_over;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: score, cycles of hold still owed, last sampled win, pending pulse.
    int m_score;
    int m_hold_left;
    bit m_prev_win;
    bit m_rr;

    int pulses;

    always #5 clk = ~clk;

    win_tally #(
        .WIDTH      (3),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .win        (win),
        .clear      (clear),
        .counter    (counter),
        .round_reset(round_reset),
        .game_over  (game_over)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_score     = 0;
        m_hold_left = 0;
        m_prev_win  = 1'b0;
        m_rr        = 1'b0;
    endtask

    task automatic model_step(input bit w, input bit c);
        bit rising;
        rising = w && !m_prev_win;
        m_rr   = 1'b0;
        if (c) begin
            m_score     = 0;
            m_hold_left = 0;
            m_rr        = 1'b1;
        end else if (m_score == MAXS) begin
            // game finished: nothing moves until clear
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) m_rr = 1'b1;
        end else if (rising) begin
            m_score++;
            if (m_score != MAXS) m_hold_left = HOLD;
        end
        m_prev_win = w;
    endtask

    task automatic check_outputs();
        check("counter", counter, m_score);
        check("round_reset", round_reset, m_rr);
        check("game_over", game_over, m_score == MAXS);
    endtask

    // Called at a negedge; drives inputs, lets one posedge pass, checks at next negedge.
    task automatic tick(input bit w, input bit c);
        win   = w;
        clear = c;
        @(posedge clk);
        model_step(w, c);
        @(negedge clk);
        check_outputs();
        pulses += round_reset;
    endtask

    task automatic async_reset();
        #1 reset = 1'b1;
        #1;
        model_reset();
        check("rst_counter", counter, 0);
        check("rst_round_reset", round_reset, 0);
        check("rst_game_over", game_over, 0);
        #1 reset = 1'b0;
    endtask

    task automatic win_pulse(input int gap);
        tick(1'b1, 1'b0);
        for (int i = 0; i < gap; i++) tick(1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        win   = 1'b0;
        clear = 1'b0;
        model_reset();
        @(negedge clk);
        check("init_counter", counter, 0);
        check("init_round_reset", round_reset, 0);
        check("init_game_over", game_over, 0);
        reset = 1'b0;

        // Single win held for 20 cycles: exactly one increment and one pulse.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0);
            if (i == 0) check("single_cnt", counter, 1);
            if (i == HOLD) check("single_rr_hi", round_reset, 1);
            if (i == HOLD + 1) check("single_rr_lo", round_reset, 0);
        end
        check("single_pulses", pulses, 1);
        check("single_final", counter, 1);

        // Fresh rise, then two more rises inside HOLD that must be discarded.
        tick(1'b0, 1'b0);
        pulses = 0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        check("hold_ignore_cnt", counter, 2);
        check("hold_ignore_pulses", pulses, 1);

        // Async reset mid-HOLD at score 2.
        tick(1'b0, 1'b1);
        win_pulse(12);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("pre_reset_cnt", counter, 2);
        async_reset();
        tick(1'b0, 1'b0);

        // Saturation: seven wins to game over, an eighth is ignored.
        for (int k = 0; k < MAXS; k++) begin
            tick(1'b1, 1'b0);
            check("sat_cnt", counter, k + 1);
            for (int i = 0; i < 11; i++) tick(1'b0, 1'b0);
        end
        check("sat_game_over", game_over, 1);
        pulses = 0;
        win_pulse(12);
        check("sat_hold_cnt", counter, MAXS);
        check("sat_no_rr", pulses, 0);

        // Clear beats a simultaneous rise in DONE; held win then needs a fresh edge.
        tick(1'b1, 1'b1);
        check("clr_cnt", counter, 0);
        check("clr_go", game_over, 0);
        check("clr_rr", round_reset, 1);
        tick(1'b1, 1'b0);
        check("clr_rr_once", round_reset, 0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        check("held_win_cnt", counter, 0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check("rewin_cnt", counter, 1);

        // Held clear keeps the pulse asserted and the score at zero.
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        check("held_clr_rr", round_reset, 1);
        check("held_clr_cnt", counter, 0);
        tick(1'b0, 1'b0);

        // Random traffic; win toggles occasionally, rare clears and async resets.
        for (int n = 0; n < 4000; n++) begin
            bit w;
            bit c;
            w = win;
            if ($urandom_range(3) == 0) w = ~w;
            c = ($urandom_range(79) == 0);
            if ($urandom_range(599) == 0) async_reset();
            tick(w, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
